silent_step: RTL and testbench

SILENT_STEP -- requirements
Module: silent_step

---
 rtl/silent_step.sv | 164 ++++++++++++++++
 tb/tb_silent_step.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silent_step.sv
// Step-limited duty/phase tracker: on each update sweep, every transducer's duty and
// phase move toward their targets by at most STEP counts; the phase moves the short way round its cycle.
module silent_step #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   update,
  input  logic [15:0]            step,
  input  logic [WIDTH*DEPTH-1:0] cycle,
  input  logic [WIDTH*DEPTH-1:0] duty_in,
  input  logic [WIDTH*DEPTH-1:0] phase_in,
  output logic [WIDTH*DEPTH-1:0] duty_out,
  output logic [WIDTH*DEPTH-1:0] phase_out,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Two guard bits above max(WIDTH,16) so that cur+cycle-mv never wraps.
  localparam int EW = ((WIDTH > 16) ? WIDTH : 16) + 2;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt;
  logic [IW-1:0]    idx_r;
  logic [15:0]      step_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] duty_r  [DEPTH];
  logic [WIDTH-1:0] phase_r [DEPTH];
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH-1:0] phase_nxt;

  logic [EW-1:0] stp;
  logic [EW-1:0] cur_d;
  logic [EW-1:0] tgt_d;
  logic [EW-1:0] cyc_c;
  logic [EW-1:0] cur_p;
  logic [EW-1:0] tgt_p;
  logic [EW-1:0] half;
  logic [EW-1:0] fwd;
  logic [EW-1:0] mv_p;
  logic [EW-1:0] sum_p;

  function automatic logic [EW-1:0] min_ext(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Sweep sequencing: IDLE waits for update, RUN walks the index, FIN is the one-cycle done slot.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (update) state_nxt = RUN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        if (idx_r == LAST) state_nxt = FIN;
        else               state_nxt = RUN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next duty and phase for the element at the current index.
  always_comb begin
    stp       = EW'(step_r);
    cur_d     = EW'(duty_r[idx_r]);
    tgt_d     = EW'(duty_in[idx_r*WIDTH +: WIDTH]);
    cyc_c     = EW'(cycle[idx_r*WIDTH +: WIDTH]);
    cur_p     = EW'(phase_r[idx_r]);
    tgt_p     = EW'(phase_in[idx_r*WIDTH +: WIDTH]);
    half      = cyc_c >> 1;
    fwd       = '0;
    mv_p      = '0;
    sum_p     = cur_p;
    duty_nxt  = duty_r[idx_r];
    phase_nxt = phase_r[idx_r];

    if (tgt_d > cur_d) begin
      duty_nxt = WIDTH'(cur_d + min_ext(stp, tgt_d - cur_d));
    end else if (tgt_d < cur_d) begin
      duty_nxt = WIDTH'(cur_d - min_ext(stp, cur_d - tgt_d));
    end else begin
      duty_nxt = duty_r[idx_r];
    end

    // Phase only moves when both ends lie inside a non-empty cycle.
    if (cyc_c == '0 || tgt_p >= cyc_c || cur_p >= cyc_c) begin
      phase_nxt = phase_r[idx_r];
    end else begin
      fwd = (tgt_p >= cur_p) ? (tgt_p - cur_p) : (tgt_p + cyc_c - cur_p);
      if (fwd == '0) begin
        phase_nxt = phase_r[idx_r];
      end else if (fwd <= half) begin
        mv_p  = min_ext(stp, fwd);
        sum_p = cur_p + mv_p;
        if (sum_p >= cyc_c) sum_p = sum_p - cyc_c;
        else                sum_p = sum_p;
        phase_nxt = WIDTH'(sum_p);
      end else begin
        mv_p  = min_ext(stp, cyc_c - fwd);
        sum_p = (cur_p >= mv_p) ? (cur_p - mv_p) : (cur_p + cyc_c - mv_p);
        phase_nxt = WIDTH'(sum_p);
      end
    end
  end

  // Control registers: state, index, latched step and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      step_r  <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt != IDLE);
      done_r  <= (state_nxt == FIN);
      if (state_r == IDLE && update) begin
        step_r <= step;
        idx_r  <= '0;
      end else if (state_r == RUN) begin
        step_r <= step_r;
        idx_r  <= (idx_r == LAST) ? '0 : idx_r + 1'b1;
      end else begin
        step_r <= step_r;
        idx_r  <= idx_r;
      end
    end
  end

  // Output element storage: only the indexed element is written, and only during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        duty_r[k]  <= '0;
        phase_r[k] <= '0;
      end
    end else if (state_r == RUN) begin
      duty_r[idx_r]  <= duty_nxt;
      phase_r[idx_r] <= phase_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign duty_out[g*WIDTH +: WIDTH]  = duty_r[g];
    assign phase_out[g*WIDTH +: WIDTH] = phase_r[g];
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_silent_step.sv
// Self-checking bench for silent_step (DEPTH=4, WIDTH=13) against a behavioural sweep model.
module tb_silent_step;

  localparam int W = 13;
  localparam int D = 4;

  logic           clk;
  logic           rst_n;
  logic           update;
  logic [15:0]    step;
  logic [W*D-1:0] cycle_v;
  logic [W*D-1:0] duty_v;
  logic [W*D-1:0] phase_v;
  logic [W*D-1:0] duty_out;
  logic [W*D-1:0] phase_out;
  logic           busy;
  logic           done;

  int tgt_duty [D];
  int tgt_phase[D];
  int cyc      [D];
  int m_duty   [D];
  int m_phase  [D];
  int n_pass;
  int n_total;

  silent_step #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .update(update), .step(step),
    .cycle(cycle_v), .duty_in(duty_v), .phase_in(phase_v),
    .duty_out(duty_out), .phase_out(phase_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Behavioural model of one complete sweep, straight from the movement rules.
  function automatic void model_sweep(int s);
    int d, c, f, np;
    for (int i = 0; i < D; i++) begin
      d = tgt_duty[i] - m_duty[i];
      if (d > 0) m_duty[i] += imin(s, d);
      else if (d < 0) m_duty[i] -= imin(s, -d);
      c = cyc[i];
      if (c != 0 && tgt_phase[i] < c && m_phase[i] < c) begin
        f = (((tgt_phase[i] - m_phase[i]) % c) + c) % c;
        np = m_phase[i];
        if (f != 0 && f <= c / 2) begin
          np = m_phase[i] + imin(s, f);
          if (np >= c) np -= c;
        end else if (f != 0) begin
          np = m_phase[i] - imin(s, c - f);
          if (np < 0) np += c;
        end
        m_phase[i] = np;
      end
    end
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < D; i++) begin
      cycle_v[i*W +: W] = W'(cyc[i]);
      duty_v[i*W +: W]  = W'(tgt_duty[i]);
      phase_v[i*W +: W] = W'(tgt_phase[i]);
    end
  endtask

  // One UPDATE pulse; edge 1 is the sampling edge. Reports the edge where DONE was first seen.
  task automatic do_sweep(input int s, output int done_at, output int done_cnt);
    int n;
    apply_inputs();
    @(negedge clk);
    step = 16'(s);
    update = 1'b1;
    @(posedge clk);
    n = 1;
    #1 update = 1'b0;
    done_at = -1;
    done_cnt = 0;
    repeat (D + 4) begin
      @(posedge clk);
      n++;
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    model_sweep(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if (duty_out !== '0 || phase_out !== '0) $display("FAIL reset_outputs duty=%h phase=%h required 0", duty_out, phase_out);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_duty_rise();
    int exp_d[3] = '{100, 200, 250};
    int da, dc;
    for (int i = 0; i < D; i++) begin
      tgt_duty[i] = 0; tgt_phase[i] = 0; cyc[i] = 4096;
    end
    tgt_duty[0] = 250;
    for (int k = 0; k < 3; k++) begin
      do_sweep(100, da, dc);
      n_total++;
      if (int'(duty_out[0 +: W]) !== exp_d[k]) $display("FAIL duty_rise_%0d got %0d required %0d", k, duty_out[0 +: W], exp_d[k]);
      else n_pass++;
      n_total++;
      if (da !== D + 1 || dc !== 1) $display("FAIL duty_rise_done_%0d at=%0d cnt=%0d required at=%0d cnt=1", k, da, dc, D + 1);
      else n_pass++;
    end
  endtask

  task automatic test_phase_wrap();
    int exp_p[3] = '{4064, 32, 50};
    int da, dc;
    tgt_phase[1] = 4000;
    do_sweep(4096, da, dc);
    n_total++;
    if (int'(phase_out[W +: W]) !== 4000) $display("FAIL phase_wrap_setup got %0d required 4000", phase_out[W +: W]);
    else n_pass++;
    tgt_phase[1] = 50;
    for (int k = 0; k < 3; k++) begin
      do_sweep(64, da, dc);
      n_total++;
      if (int'(phase_out[W +: W]) !== exp_p[k]) $display("FAIL phase_wrap_%0d got %0d required %0d", k, phase_out[W +: W], exp_p[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backward_tie();
    int da, dc;
    tgt_phase[2] = 100;
    do_sweep(200, da, dc);
    tgt_phase[2] = 4000;
    tgt_phase[3] = 2048;
    do_sweep(64, da, dc);
    n_total++;
    if (int'(phase_out[2*W +: W]) !== 36) $display("FAIL phase_backward got %0d required 36", phase_out[2*W +: W]);
    else n_pass++;
    n_total++;
    if (int'(phase_out[3*W +: W]) !== 64) $display("FAIL phase_tie got %0d required 64", phase_out[3*W +: W]);
    else n_pass++;
  endtask

  task automatic test_random();
    int da, dc, s;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < D; i++) begin
        cyc[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8191));
        tgt_phase[i] = imin(int'($urandom_range(0, 8191)) % (cyc[i] + 3), 8191);
        tgt_duty[i] = $urandom_range(0, 8191);
      end
      s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 600));
      do_sweep(s, da, dc);
      for (int i = 0; i < D; i++) begin
        n_total++;
        if (int'(duty_out[i*W +: W]) !== m_duty[i] || int'(phase_out[i*W +: W]) !== m_phase[i])
          $display("FAIL random_%0d_el%0d duty=%0d phase=%0d required duty=%0d phase=%0d",
                   k, i, duty_out[i*W +: W], phase_out[i*W +: W], m_duty[i], m_phase[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, cnt;
    for (int i = 0; i < D; i++) begin
      cyc[i] = 4096; tgt_duty[i] = 4000 + 100 * i; tgt_phase[i] = 1000 * i;
    end
    apply_inputs();
    @(negedge clk);
    step = 16'd50;
    update = 1'b1;
    d1 = -1; d2 = -1; cnt = 0;
    for (int n = 1; n <= 3 * (D + 2) + 2; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        cnt++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 2 * (D + 2) - 1 + 1 - 1) update = 1'b0;
    end
    model_sweep(50);
    model_sweep(50);
    n_total++;
    if (d1 !== D + 1 || d2 - d1 !== D + 2 || cnt !== 2)
      $display("FAIL back_to_back done1=%0d done2=%0d cnt=%0d required %0d %0d 2", d1, d2, cnt, D + 1, 2 * D + 3);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      n_total++;
      if (int'(duty_out[i*W +: W]) !== m_duty[i] || int'(phase_out[i*W +: W]) !== m_phase[i])
        $display("FAIL back_to_back_el%0d duty=%0d phase=%0d required duty=%0d phase=%0d",
                 i, duty_out[i*W +: W], phase_out[i*W +: W], m_duty[i], m_phase[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_mid();
    int cnt;
    apply_inputs();
    @(negedge clk);
    step = 16'd30;
    update = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 3 * D; n++) begin
      @(posedge clk);
      #1;
      update = (n == 2);
      if (done === 1'b1) cnt++;
    end
    model_sweep(30);
    n_total++;
    if (cnt !== 1 || busy !== 1'b0) $display("FAIL ignore_mid done_cnt=%0d busy=%b required 1 0", cnt, busy);
    else n_pass++;
    n_total++;
    if (int'(duty_out[0 +: W]) !== m_duty[0] || int'(phase_out[3*W +: W]) !== m_phase[3])
      $display("FAIL ignore_mid_values duty0=%0d phase3=%0d required %0d %0d",
               duty_out[0 +: W], phase_out[3*W +: W], m_duty[0], m_phase[3]);
    else n_pass++;
  endtask

  task automatic test_step_zero();
    logic [W*D-1:0] d0, p0;
    int da, dc;
    d0 = duty_out;
    p0 = phase_out;
    for (int i = 0; i < D; i++) begin
      tgt_duty[i] = 8191 - i; tgt_phase[i] = 7 + i; cyc[i] = 4096;
    end
    do_sweep(0, da, dc);
    n_total++;
    if (duty_out !== d0 || phase_out !== p0) $display("FAIL step_zero duty=%h phase=%h required %h %h", duty_out, phase_out, d0, p0);
    else n_pass++;
    n_total++;
    if (dc !== 1 || da !== D + 1) $display("FAIL step_zero_done at=%0d cnt=%0d required %0d 1", da, dc, D + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int i = 0; i < D; i++) begin
      tgt_duty[i] = 3000; tgt_phase[i] = 10; cyc[i] = 4096;
    end
    apply_inputs();
    @(negedge clk);
    step = 16'd500;
    update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (duty_out !== '0 || phase_out !== '0 || busy !== 1'b0)
      $display("FAIL reset_mid duty=%h phase=%h busy=%b required 0 0 0", duty_out, phase_out, busy);
    else n_pass++;
    cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    n_total++;
    if (cnt !== 0) $display("FAIL reset_mid_no_done bad_cycles=%0d required 0", cnt);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      m_duty[i] = 0; m_phase[i] = 0;
    end
  endtask

  task automatic test_phase_hold();
    int da, dc;
    for (int i = 0; i < D; i++) begin
      tgt_duty[i] = 0; tgt_phase[i] = 0; cyc[i] = 4096;
    end
    tgt_phase[2] = 500;
    do_sweep(600, da, dc);
    cyc[0] = 1000; tgt_phase[0] = 1500;
    cyc[1] = 0;    tgt_phase[1] = 20;
    cyc[2] = 300;  tgt_phase[2] = 10;
    cyc[3] = 100;  tgt_phase[3] = 99;
    do_sweep(40, da, dc);
    n_total++;
    if (int'(phase_out[0 +: W]) !== 0) $display("FAIL hold_target_ge_cycle got %0d required 0", phase_out[0 +: W]);
    else n_pass++;
    n_total++;
    if (int'(phase_out[W +: W]) !== 0) $display("FAIL hold_cycle_zero got %0d required 0", phase_out[W +: W]);
    else n_pass++;
    n_total++;
    if (int'(phase_out[2*W +: W]) !== 500) $display("FAIL hold_current_ge_cycle got %0d required 500", phase_out[2*W +: W]);
    else n_pass++;
    n_total++;
    if (int'(phase_out[3*W +: W]) !== 99) $display("FAIL hold_control_backward got %0d required 99", phase_out[3*W +: W]);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    update = 1'b0;
    step = 16'd0;
    cycle_v = '0;
    duty_v = '0;
    phase_v = '0;
    for (int i = 0; i < D; i++) begin
      tgt_duty[i] = 0; tgt_phase[i] = 0; cyc[i] = 0; m_duty[i] = 0; m_phase[i] = 0;
    end
    test_reset();
    test_duty_rise();
    test_phase_wrap();
    test_backward_tie();
    test_random();
    test_back_to_back();
    test_ignore_mid();
    test_step_zero();
    test_reset_mid();
    test_phase_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
